// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI master and its divider.
package spi_pkg;

  localparam int DEF_CLK_DIV = 5;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;
  localparam int FRAME_BITS  = 1 + SPI_ADDR_W + SPI_DATA_W;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_GAP      = 3'd4
  } spi_state_t;

endpackage

// File: rtl/spi_if.sv
// Host request/response signals plus the four-wire serial bus of the SPI master.
interface spi_if import spi_pkg::*; #(
  parameter int ADDR_W = SPI_ADDR_W,
  parameter int DATA_W = SPI_DATA_W
);

  // Handshake: a request is taken on any rising CLK edge where start=1 and
  // busy=0; busy then stays high until the frame and its gap finish, and done
  // pulses for exactly one cycle when the frame ends. start while busy is dropped.
  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              CS;
  logic              SCLK;
  logic              MOSI;
  logic              MISO;

  modport master (
    input  start, rw, addr, wdata, MISO,
    output busy, done, rdata, CS, SCLK, MOSI
  );

  modport slave (
    output start, rw, addr, wdata, MISO,
    input  busy, done, rdata, CS, SCLK, MOSI
  );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period counter: ticks every CLK_DIV cycles while running, and splits the
// tick into rise/fall strobes according to the current SCLK level.
module spi_clk_div import spi_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic CLK,
  input  logic RESET,
  input  logic run,
  input  logic level,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET || !run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == CW'(CLK_DIV - 1));
  assign rise = tick && !level;
  assign fall = tick && level;

endmodule

// File: rtl/spi_master.sv
// Mode-0, MSB-first SPI master: one {rw, addr, data} frame per accepted request,
// with registered CS/SCLK/MOSI and read data captured from the last DATA_W bits.
module spi_master import spi_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int ADDR_W  = SPI_ADDR_W,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic       CLK,
  input  logic       RESET,
  spi_if.master      bus,
  output spi_state_t fsm_state
);

  localparam int FW = 1 + ADDR_W + DATA_W;
  localparam int BW = $clog2(FW);

  spi_state_t        state;
  spi_state_t        state_nx;
  logic              tick;
  logic              rise;
  logic              fall;
  logic              accept;
  logic              sample;
  logic              shift;
  logic              frame_end;
  logic [FW-1:0]     frame;
  logic [FW-1:0]     tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [BW-1:0]     bit_cnt;
  logic              hold;
  logic              rw_q;
  logic              cs_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rdata_q;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .CLK   (CLK),
    .RESET (RESET),
    .run   (state != ST_IDLE),
    .level (state == ST_SHIFT_HI),
    .tick  (tick),
    .rise  (rise),
    .fall  (fall)
  );

  // Reads send a zero data field; the slave drives its answer during those bits.
  assign frame = {bus.rw, bus.addr, (bus.rw == RW_READ) ? {DATA_W{1'b0}} : bus.wdata};

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    sample    = 1'b0;
    shift     = 1'b0;
    frame_end = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx = ST_SETUP;
          accept   = 1'b1;
        end
      end
      ST_SETUP: begin
        if (rise) begin
          state_nx = ST_SHIFT_HI;
          sample   = 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (fall) begin
          state_nx = ST_SHIFT_LO;
          shift    = 1'b1;
        end
      end
      ST_SHIFT_LO: begin
        // After the last bit this low phase is the CS hold time.
        if (rise) begin
          if (hold) begin
            state_nx  = ST_GAP;
            frame_end = 1'b1;
          end else begin
            state_nx = ST_SHIFT_HI;
            sample   = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ST_IDLE;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      hold    <= 1'b0;
      rw_q    <= RW_WRITE;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state  <= state_nx;
      cs_q   <= (state_nx == ST_IDLE) || (state_nx == ST_GAP);
      sclk_q <= (state_nx == ST_SHIFT_HI);
      busy_q <= (state_nx != ST_IDLE);
      done_q <= frame_end;
      if (accept) begin
        tx_sh   <= frame;
        rw_q    <= bus.rw;
        mosi_q  <= frame[FW-1];
        bit_cnt <= '0;
        hold    <= 1'b0;
      end
      if (sample) begin
        rx_sh <= {rx_sh[DATA_W-2:0], bus.MISO};
      end
      if (shift) begin
        if (bit_cnt == BW'(FW - 1)) begin
          hold   <= 1'b1;
          mosi_q <= 1'b0;
        end else begin
          tx_sh   <= tx_sh << 1;
          mosi_q  <= tx_sh[FW-2];
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (frame_end) begin
        hold <= 1'b0;
        if (rw_q == RW_READ) begin
          rdata_q <= rx_sh;
        end
      end
    end
  end

  assign bus.CS    = cs_q;
  assign bus.SCLK  = sclk_q;
  assign bus.MOSI  = mosi_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_spi_master.sv
// Randomised and directed bench for spi_master with a register-slave model and
// a frame-level scoreboard fed by the request driver.
module tb_spi_master;
  import spi_pkg::*;

  localparam int CLK_DIV = DEF_CLK_DIV;
  localparam int DIV2    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  spi_if bus ();
  spi_if bus2 ();
  spi_state_t st1;
  spi_state_t st2;

  spi_master #(.CLK_DIV(CLK_DIV)) dut (.CLK(clk), .RESET(rst), .bus(bus), .fsm_state(st1));
  spi_master #(.CLK_DIV(DIV2))    dut2 (.CLK(clk), .RESET(rst), .bus(bus2), .fsm_state(st2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // entry = {expected 16-bit MOSI frame, expected rdata after the frame}
  logic [23:0] exp_q[$];
  logic [7:0]  resp_q[$];
  logic [7:0]  model_rdata = 8'h00;

  // ---------------- slave model (mode 0, MSB first) ----------------
  logic [15:0] resp_sh    = 16'h0000;
  logic        s_cs_prev  = 1'b1;
  logic        s_sclk_prev = 1'b0;
  assign bus.MISO  = resp_sh[15];
  assign bus2.MISO = 1'b0;

  always @(negedge clk) begin
    if (!bus.CS && s_cs_prev) begin
      resp_sh = {8'h00, (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00};
    end else if (!bus.CS && !bus.SCLK && s_sclk_prev) begin
      resp_sh = resp_sh << 1;
    end
    s_cs_prev   = bus.CS;
    s_sclk_prev = bus.SCLK;
  end

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          cs_fall_cyc = 0;
  int          cs_high_cnt = 0;
  int          rises = 0;
  int          bad_sclk = 0;
  int          bad_mosi = 0;
  logic [15:0] mosi_bits = 16'h0;
  logic        m_cs_prev = 1'b1;
  logic        m_sclk_prev = 1'b0;
  logic        done_prev = 1'b0;
  logic        seen_fall = 1'b0;
  logic [23:0] e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_cs_prev = 1'b1; m_sclk_prev = 1'b0; done_prev = 1'b0; seen_fall = 1'b0;
      rises = 0; mosi_bits = 16'h0; bad_sclk = 0; bad_mosi = 0; cs_high_cnt = 0;
    end else begin
      if (bus.CS) cs_high_cnt++;
      if (!bus.CS && m_cs_prev) begin
        if (seen_fall) check("cs_high_between_frames", 32'(cs_high_cnt >= CLK_DIV + 1), 1);
        seen_fall = 1'b1; cs_fall_cyc = cyc; cs_high_cnt = 0;
        rises = 0; mosi_bits = 16'h0; bad_mosi = 0;
      end
      if (bus.SCLK && !m_sclk_prev) begin
        rises++;
        mosi_bits = {mosi_bits[14:0], bus.MOSI};
      end
      if (bus.SCLK && bus.CS) bad_sclk++;
      if (!bus.CS && !bus.SCLK && rises == 16 && bus.MOSI) bad_mosi++;
      if (bus.done) begin
        if (done_prev) begin
          check("done_width", 2, 1);
        end else if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("mosi_frame", mosi_bits, e[23:8]);
          check("sclk_rises", rises, 16);
          check("cs_low_cycles", cyc - cs_fall_cyc, CLK_DIV * 33);
          check("rdata", bus.rdata, e[7:0]);
          check("sclk_high_while_cs_high", bad_sclk, 0);
          check("mosi_zero_in_hold", bad_mosi, 0);
        end
      end
      done_prev   = bus.done;
      m_cs_prev   = bus.CS;
      m_sclk_prev = bus.SCLK;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] w,
                       input logic [7:0] resp);
    int t = 0;
    while (bus.busy && t < 400) begin @(negedge clk); t++; end
    if (bus.busy) check("idle_timeout", 1, 0);
    bus.start = 1'b1; bus.rw = r; bus.addr = a; bus.wdata = w;
    if (r) model_rdata = resp;
    exp_q.push_back({r, a, (r ? 8'h00 : w), model_rdata});
    resp_q.push_back(resp);
    @(negedge clk);
    check("accepted", bus.busy, 1);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.busy) && t < 2000) begin @(negedge clk); t++; end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!bus.done && t < 400) begin @(negedge clk); t++; end
    check("done_seen", bus.done, 1);
  endtask

  // ---------------- stimulus ----------------
  int          t;
  int          cs_low;
  int          r2;
  int          first_r;
  int          second_r;
  int          last_r;
  logic        done2;
  logic        prev2;
  logic [15:0] bits2;

  initial begin
    bus.start = 0; bus.rw = 0; bus.addr = '0; bus.wdata = '0;
    bus2.start = 0; bus2.rw = 0; bus2.addr = '0; bus2.wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs", bus.CS, 1);
    check("rst_sclk", bus.SCLK, 0);
    check("rst_mosi", bus.MOSI, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_state", st1, ST_IDLE);
    check("rst_state2", st2, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);

    // directed write and read of 0x55
    issue(1'b0, 7'h55, 8'h33, 8'hA5);
    drain();
    issue(1'b1, 7'h55, 8'hFF, 8'h33);
    drain();

    // back-to-back: start held from done until accepted
    issue(1'b0, 7'h11, 8'h22, 8'h00);
    wait_done();
    bus.start = 1'b1; bus.rw = 1'b1; bus.addr = 7'h66; bus.wdata = 8'h99;
    model_rdata = 8'hC7;
    exp_q.push_back({1'b1, 7'h66, 8'h00, model_rdata});
    resp_q.push_back(8'hC7);
    t = 0;
    while (bus.busy && t < 100) begin @(negedge clk); t++; end
    while (!bus.busy && t < 100) begin @(negedge clk); t++; end
    check("b2b_accept_cycles", t, CLK_DIV + 1);
    bus.start = 1'b0;
    drain();

    // start pulsed around bit 5 must be ignored
    issue(1'b0, 7'h3C, 8'h5A, 8'h00);
    repeat (CLK_DIV * 11) @(negedge clk);
    bus.start = 1'b1; bus.rw = 1'b1; bus.addr = 7'h12; bus.wdata = 8'hAA;
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // reset during bit 10 aborts the frame silently
    issue(1'b1, 7'h2A, 8'h00, 8'h5C);
    repeat (CLK_DIV * 21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs", bus.CS, 1);
    check("abort_sclk", bus.SCLK, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_rdata", bus.rdata, 0);
    exp_q.delete();
    model_rdata = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (CLK_DIV * 4) @(negedge clk);
    issue(1'b0, 7'h7F, 8'h01, 8'h00);
    drain();

    // randomised traffic
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    drain();

    // CLK_DIV=2 instance, same write as the first directed frame
    bus2.start = 1'b1; bus2.rw = 1'b0; bus2.addr = 7'h55; bus2.wdata = 8'h33;
    @(negedge clk);
    bus2.start = 1'b0;
    cs_low = 0; r2 = 0; first_r = -1; second_r = -1; last_r = 0;
    done2 = 1'b0; prev2 = 1'b0; bits2 = 16'h0;
    for (int i = 0; i < 200 && !done2; i++) begin
      if (bus2.done) begin
        done2 = 1'b1;
      end else begin
        if (!bus2.CS) cs_low++;
        if (bus2.SCLK && !prev2) begin
          r2++;
          bits2 = {bits2[14:0], bus2.MOSI};
          if (first_r < 0) first_r = i;
          else if (second_r < 0) second_r = i;
          last_r = i;
        end
        prev2 = bus2.SCLK;
        @(negedge clk);
      end
    end
    check("div2_done", done2, 1);
    check("div2_cs_low", cs_low, 66);
    check("div2_rises", r2, 16);
    check("div2_period", second_r - first_r, 4);
    check("div2_span", last_r - first_r, 60);
    check("div2_mosi", bits2, 16'h5533);
    check("div2_rdata", bus2.rdata, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
